// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants and FSM encoding for the instruction fetch unit.
package instruction_fetch_unit_pkg;

  // Text segment base that the PC returns to on reset.
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

  // Low two PC bits of a word-aligned instruction address.
  localparam logic [1:0] ALIGN_OK = 2'b00;

  // Byte distance between consecutive instructions.
  localparam int unsigned PC_INCR = 4;

  // Fetch controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit_fifo.sv
// Two-entry instruction buffer holding {pc, instruction} pairs.
// A flush empties it and overrides any same-cycle push or pop.
// The head outputs read as zero whenever the buffer is empty.
module instruction_fetch_unit_fifo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] push_pc,
  input  logic [WIDTH-1:0] push_instr,
  output logic [WIDTH-1:0] head_pc,
  output logic [WIDTH-1:0] head_instr,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] pc_mem    [2];
  logic [WIDTH-1:0] instr_mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic             do_push;
  logic             do_pop;

  // Guard against overflow and underflow so the pointers never desynchronise.
  always_comb begin
    do_push = push && (count != 2'd2);
    do_pop  = pop && (count != 2'd0);
  end

  // Pointer and occupancy bookkeeping; flush has priority over push and pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Entry storage; contents are only visible through the count-qualified head.
  always_ff @(posedge clk) begin
    if (!flush && do_push) begin
      pc_mem[wr_ptr]    <= push_pc;
      instr_mem[wr_ptr] <= push_instr;
    end
  end

  // Head entry, forced to zero while empty.
  always_comb begin
    head_pc    = '0;
    head_instr = '0;
    if (count != 2'd0) begin
      head_pc    = pc_mem[rd_ptr];
      head_instr = instr_mem[rd_ptr];
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, requests word-aligned fetches,
// buffers returned instructions with their PC and hands them to decode.
//
// Handshakes:
//   memory side : a request is live while Fetch_Req_o=1; the word for
//                 Fetch_Address_o is taken on the edge where Mem_Ready_i=1,
//                 otherwise the same address is held.
//   decode side : the head entry is transferred on the edge where
//                 Valid_o=1 and Decode_Ready_i=1; Valid_o never depends
//                 on Decode_Ready_i.
//   redirect    : Redirect_i flushes the buffer, drops any same-cycle
//                 transfer on either side and loads Redirect_PC_i.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT),
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [DATA_WIDTH-1:0] Fetch_Address_o,
  output logic                  Fetch_Req_o,
  input  logic                  Mem_Ready_i,
  input  logic [DATA_WIDTH-1:0] Instruction_i,
  output logic [DATA_WIDTH-1:0] Instruction_o,
  output logic [DATA_WIDTH-1:0] PC_o,
  output logic                  Valid_o,
  input  logic                  Decode_Ready_i,
  input  logic                  Redirect_i,
  input  logic [DATA_WIDTH-1:0] Redirect_PC_i,
  output logic                  Misaligned_o,
  output fetch_state_e          fsm_state
);

  // No request is issued at full occupancy, even with a same-cycle pop;
  // this costs a bubble but keeps the buffer free of bypass paths.
  localparam logic [1:0] FULL_COUNT = 2'(FIFO_DEPTH);

  fetch_state_e          state;
  fetch_state_e          state_next;
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] pc_next;
  logic [1:0]            count;
  logic                  redirect_take;
  logic                  target_misaligned;
  logic                  push;
  logic                  pop;

  // Controller state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next state, request/transfer strobes and next PC.
  always_comb begin
    state_next        = state;
    target_misaligned = (Redirect_PC_i[1:0] != ALIGN_OK);
    redirect_take     = Redirect_i && (state != ST_HALT);
    Fetch_Req_o       = (state == ST_FETCH) && (count < FULL_COUNT) && !Redirect_i;
    push              = Fetch_Req_o && Mem_Ready_i;
    pop               = Valid_o && Decode_Ready_i;
    pc_next           = pc;
    case (state)
      ST_IDLE:  state_next = (Redirect_i && target_misaligned) ? ST_HALT : ST_FETCH;
      ST_FETCH: if (Redirect_i && target_misaligned) state_next = ST_HALT;
      ST_HALT:  state_next = ST_HALT;
      default:  state_next = ST_IDLE;
    endcase
    if (redirect_take) pc_next = Redirect_PC_i;
    else if (push)     pc_next = pc + DATA_WIDTH'(PC_INCR);
  end

  // Program counter; the increment wraps modulo 2^DATA_WIDTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc <= RESET_PC;
    else       pc <= pc_next;
  end

  instruction_fetch_unit_fifo #(
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .flush      (redirect_take),
    .push_pc    (pc),
    .push_instr (Instruction_i),
    .head_pc    (PC_o),
    .head_instr (Instruction_o),
    .count      (count)
  );

  // Decode-facing status; HALT is only entered through a flush, so the
  // buffer is already empty there and the head reads as zero.
  always_comb begin
    Fetch_Address_o = pc;
    Valid_o         = (count != 2'd0) && (state != ST_HALT);
    Misaligned_o    = (state == ST_HALT);
    fsm_state       = state;
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios followed
// by randomized traffic, checked against a queue-level fetch model.
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Fetch_Address_o;
  logic        Fetch_Req_o;
  logic        Mem_Ready_i = 1'b0;
  logic [31:0] Instruction_i;
  logic [31:0] Instruction_o;
  logic [31:0] PC_o;
  logic        Valid_o;
  logic        Decode_Ready_i = 1'b0;
  logic        Redirect_i = 1'b0;
  logic [31:0] Redirect_PC_i = 32'h0;
  logic        Misaligned_o;
  fetch_state_e fsm_state;

  int checks = 0;
  int failures = 0;

  // Reference model: program-order stream of fetched words.
  logic [31:0] m_pc = RST_PC;
  bit          m_started = 1'b0;
  bit          m_halted = 1'b0;
  int          m_cnt = 0;
  logic [63:0] exp_q[$];

  bit          exp_req;
  bit          m_req;
  logic [63:0] head;

  instruction_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .Fetch_Address_o (Fetch_Address_o),
    .Fetch_Req_o     (Fetch_Req_o),
    .Mem_Ready_i     (Mem_Ready_i),
    .Instruction_i   (Instruction_i),
    .Instruction_o   (Instruction_o),
    .PC_o            (PC_o),
    .Valid_o         (Valid_o),
    .Decode_Ready_i  (Decode_Ready_i),
    .Redirect_i      (Redirect_i),
    .Redirect_PC_i   (Redirect_PC_i),
    .Misaligned_o    (Misaligned_o),
    .fsm_state       (fsm_state)
  );

  // Clock: period 10, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Program memory contents as a function of address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  assign Instruction_i = mem_word(Fetch_Address_o);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(Valid_o), 32'h0);
    check({tag, "_req"}, 32'(Fetch_Req_o), 32'h0);
    check({tag, "_addr"}, Fetch_Address_o, RST_PC);
    check({tag, "_pc_o"}, PC_o, 32'h0);
    check({tag, "_instr_o"}, Instruction_o, 32'h0);
    check({tag, "_misaligned"}, 32'(Misaligned_o), 32'h0);
  endtask

  // Apply inputs, then advance past the next rising edge.
  task automatic step(input logic mr, input logic dr, input logic rd, input logic [31:0] rpc);
    Mem_Ready_i = mr;
    Decode_Ready_i = dr;
    Redirect_i = rd;
    Redirect_PC_i = rpc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    Mem_Ready_i = 1'b0;
    Decode_Ready_i = 1'b0;
    Redirect_i = 1'b0;
    Redirect_PC_i = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;
  endtask

  // Model update on each edge: flush on redirect, otherwise accept/fetch.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc = RST_PC;
      m_started = 1'b0;
      m_halted = 1'b0;
      m_cnt = 0;
      exp_q.delete();
    end else if (!m_started) begin
      m_started = 1'b1;
      if (Redirect_i) begin
        m_pc = Redirect_PC_i;
        m_halted = (Redirect_PC_i[1:0] != 2'b00);
      end
    end else if (!m_halted) begin
      if (Redirect_i) begin
        exp_q.delete();
        m_cnt = 0;
        m_pc = Redirect_PC_i;
        m_halted = (Redirect_PC_i[1:0] != 2'b00);
      end else begin
        m_req = (m_cnt < 2);
        if (m_cnt != 0 && Decode_Ready_i) m_cnt--;
        if (m_req && Mem_Ready_i) begin
          exp_q.push_back({m_pc, mem_word(m_pc)});
          m_cnt++;
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  // Monitor: compare outputs mid-cycle, pop the scoreboard on each accept.
  always @(negedge clk) begin
    if (!reset) begin
      exp_req = m_started && !m_halted && (m_cnt < 2) && !Redirect_i;
      check("fetch_req", 32'(Fetch_Req_o), 32'(exp_req));
      check("fetch_addr", Fetch_Address_o, m_pc);
      check("valid", 32'(Valid_o), 32'(m_cnt != 0 && !m_halted));
      check("misaligned", 32'(Misaligned_o), 32'(m_halted));
      if (Valid_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL head_entry actual_pc=%h required=no entry t=%0t", PC_o, $time);
        end else begin
          head = exp_q[0];
          check("head_pc", PC_o, head[63:32]);
          check("head_instr", Instruction_o, head[31:0]);
          if (Decode_Ready_i) void'(exp_q.pop_front());
        end
      end else if (m_cnt == 0) begin
        check("empty_pc", PC_o, 32'h0);
        check("empty_instr", Instruction_o, 32'h0);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Driver: directed scenarios, then randomized traffic.
  initial begin
    logic [31:0] tmp;
    logic [31:0] rpc;
    int r;
    int halt_cycles;
    bit found;

    // Startup latency and steady streaming.
    do_reset();
    step(1, 1, 0, 0);
    check("start_valid_edge1", 32'(Valid_o), 32'h0);
    step(1, 1, 0, 0);
    check("start_valid_edge2", 32'(Valid_o), 32'h1);
    check("start_pc0", PC_o, 32'h0040_0000);
    step(1, 1, 0, 0);
    check("start_pc1", PC_o, 32'h0040_0004);
    step(1, 1, 0, 0);
    check("start_pc2", PC_o, 32'h0040_0008);

    // Decode stall fills exactly two entries.
    do_reset();
    repeat (6) step(1, 0, 0, 0);
    check("stall_req", 32'(Fetch_Req_o), 32'h0);
    check("stall_addr", Fetch_Address_o, 32'h0040_0008);
    check("stall_head", PC_o, 32'h0040_0000);

    // Drain, then memory wait at 0x0040_0010.
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1, 1, 0, 0);
      if (Fetch_Address_o == 32'h0040_0010) found = 1'b1;
    end
    check("reach_0x10", 32'(found), 32'h1);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0);
      check("memwait_addr", Fetch_Address_o, 32'h0040_0010);
    end
    check("memwait_valid", 32'(Valid_o), 32'h0);
    step(1, 1, 0, 0);
    check("memwait_resume_valid", 32'(Valid_o), 32'h1);
    check("memwait_resume_pc", PC_o, 32'h0040_0010);

    // Redirect with a full buffer.
    repeat (3) step(1, 0, 0, 0);
    step(1, 1, 1, 32'h0040_0100);
    check("redir_valid", 32'(Valid_o), 32'h0);
    check("redir_addr", Fetch_Address_o, 32'h0040_0100);
    step(1, 1, 0, 0);
    check("redir_target_valid", 32'(Valid_o), 32'h1);
    check("redir_target_pc", PC_o, 32'h0040_0100);

    // PC wrap at the top of the address space.
    step(1, 1, 1, 32'hFFFF_FFFC);
    step(1, 1, 0, 0);
    check("wrap_pc_top", PC_o, 32'hFFFF_FFFC);
    step(1, 1, 0, 0);
    check("wrap_pc_zero", PC_o, 32'h0000_0000);

    // Misaligned redirect halts until reset.
    step(1, 1, 1, 32'h0040_0102);
    check("halt_misaligned", 32'(Misaligned_o), 32'h1);
    check("halt_valid", 32'(Valid_o), 32'h0);
    step(1, 1, 0, 0);
    check("halt_req", 32'(Fetch_Req_o), 32'h0);
    repeat (4) step(1, 1, 1, 32'h0040_0200);
    check("halt_sticky", 32'(Misaligned_o), 32'h1);
    do_reset();
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    check("restart_pc", PC_o, RST_PC);
    check("restart_misaligned", 32'(Misaligned_o), 32'h0);

    // Randomized traffic with an asynchronous reset mid-stream.
    halt_cycles = 0;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        #3;
        reset = 1'b1;
        #1;
        check_reset_outputs("async");
        @(posedge clk);
        #1;
        reset = 1'b0;
      end
      if (m_halted) halt_cycles++;
      if (halt_cycles > 4) begin
        do_reset();
        halt_cycles = 0;
      end
      r = $urandom_range(0, 199);
      tmp = $urandom();
      rpc = {tmp[31:2], 2'b00};
      if (r == 0) rpc[1:0] = 2'b10;
      if (r == 1) rpc = 32'hFFFF_FFF8;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7, r < 10, rpc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
